// File: rtl/invaders_pkg.sv
// Shared formation geometry, index/map types and FSM encoding for the enemy kill path.
package invaders_pkg;

    localparam int COLS      = 10;
    localparam int ROWS      = 6;
    localparam int ENEMY_W   = 16;
    localparam int ENEMY_H   = 16;
    localparam int COL_PITCH = 24;
    localparam int ROW_PITCH = 20;

    typedef logic [9:0]      pix_t;
    typedef logic [9:0][5:0] enemy_map_t;

    typedef struct packed {
        logic [3:0] col;
        logic [2:0] row;
    } enemy_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        MARK,
        STROBE,
        DONE
    } hit_state_t;

endpackage

// File: rtl/cell_scanner.sv
// Walks the enemy formation col-major, one cell per step, tracking the cell origin
// with adders only (row pitch inside a column, column pitch at row wrap).
module cell_scanner
    import invaders_pkg::*;
#(
    parameter int N_COLS  = invaders_pkg::COLS,
    parameter int N_ROWS  = invaders_pkg::ROWS,
    parameter int C_PITCH = invaders_pkg::COL_PITCH,
    parameter int R_PITCH = invaders_pkg::ROW_PITCH
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [9:0]  fleet_x,
    input  logic [9:0]  fleet_y,
    output enemy_idx_t  idx,
    output logic [10:0] ex,
    output logic [10:0] ey,
    output logic        last
);

    logic [10:0] fy;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            ex  <= '0;
            ey  <= '0;
            fy  <= '0;
        end else if (load) begin
            idx <= '0;
            ex  <= {1'b0, fleet_x};
            ey  <= {1'b0, fleet_y};
            fy  <= {1'b0, fleet_y};
        end else if (step) begin
            // 11-bit origins keep a fleet near the right/bottom edge from wrapping to 0
            if (idx.row == 3'(N_ROWS - 1)) begin
                idx.row <= '0;
                idx.col <= idx.col + 4'd1;
                ey      <= fy;
                ex      <= ex + 11'(C_PITCH);
            end else begin
                idx.row <= idx.row + 3'd1;
                ey      <= ey + 11'(R_PITCH);
            end
        end
    end

    assign last = (idx.col == 4'(N_COLS - 1)) && (idx.row == 3'(N_ROWS - 1));

endmodule

// File: rtl/enemy_hit_detector.sv
// Per-frame bullet vs. formation scan; emits at most one kill strobe per frame.
// Optional KILL_COUNT_EN adds a saturating kill counter and wave_clear level.
module enemy_hit_detector
    import invaders_pkg::*;
#(
    parameter int COLS      = invaders_pkg::COLS,
    parameter int ROWS      = invaders_pkg::ROWS,
    parameter int ENEMY_W   = invaders_pkg::ENEMY_W,
    parameter int ENEMY_H   = invaders_pkg::ENEMY_H,
    parameter int COL_PITCH = invaders_pkg::COL_PITCH,
    parameter int ROW_PITCH = invaders_pkg::ROW_PITCH
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            frame_start,
    input  logic            bullet_active,
    input  logic [9:0]      bullet_x,
    input  logic [9:0]      bullet_y,
    input  logic [9:0]      fleet_x,
    input  logic [9:0]      fleet_y,
    input  logic [9:0][5:0] enemy_status,
    output logic [6:0]      enemy_hit,
    output logic            collision,
    output logic            bullet_kill,
    output logic            busy
`ifdef KILL_COUNT_EN
    ,
    output logic [5:0]      kills,
    output logic            wave_clear
`endif
);

    function automatic logic in_span(input logic [10:0] p, input logic [10:0] org,
                                     input logic [10:0] size);
        return (p >= org) && (p <= org + size - 11'd1);
    endfunction

    hit_state_t  state, state_n;
    logic        load, step, hit_en, match, last;
    logic [9:0]  bx, by;
    enemy_idx_t  idx;
    logic [10:0] ex, ey;

    cell_scanner #(
        .N_COLS (COLS),
        .N_ROWS (ROWS),
        .C_PITCH(COL_PITCH),
        .R_PITCH(ROW_PITCH)
    ) u_scan (
        .Clk    (Clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .fleet_x(fleet_x),
        .fleet_y(fleet_y),
        .idx    (idx),
        .ex     (ex),
        .ey     (ey),
        .last   (last)
    );

    assign match = enemy_status[idx.col][idx.row]
                && in_span({1'b0, bx}, ex, 11'(ENEMY_W))
                && in_span({1'b0, by}, ey, 11'(ENEMY_H));

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        hit_en  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_n = bullet_active ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_n = bullet_active ? SCAN : DONE;
                end else begin
                    step = 1'b1;
                    if (match) begin
                        hit_en  = 1'b1;
                        state_n = MARK;
                    end else if (last) begin
                        state_n = DONE;
                    end
                end
            end
            // MARK gives enemy_hit a full cycle of setup before the strobe edge
            MARK:    state_n = STROBE;
            STROBE:  state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            enemy_hit <= '0;
        end else begin
            state <= state_n;
            if (hit_en)
                enemy_hit <= idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (load) begin
            bx <= bullet_x;
            by <= bullet_y;
        end
    end

    assign collision   = (state == STROBE);
    assign bullet_kill = (state == STROBE);
    assign busy        = (state == SCAN) || (state == MARK) || (state == STROBE);

`ifdef KILL_COUNT_EN
    localparam logic [5:0] KILL_MAX = 6'(COLS * ROWS);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            kills <= '0;
        else if ((state == STROBE) && (kills != KILL_MAX))
            kills <= kills + 6'd1;
    end

    assign wave_clear = (kills == KILL_MAX);
`endif

endmodule

// File: tb/tb_enemy_hit_detector.sv
// Directed bench for enemy_hit_detector: per-cycle latency, misses, abort, wrap and reset.
module tb_enemy_hit_detector;

    logic            Clk;
    logic            reset;
    logic            frame_start;
    logic            bullet_active;
    logic [9:0]      bullet_x, bullet_y, fleet_x, fleet_y;
    logic [9:0][5:0] enemy_status;
    logic [6:0]      enemy_hit;
    logic            collision, bullet_kill, busy;
`ifdef KILL_COUNT_EN
    logic [5:0]      kills;
    logic            wave_clear;
`endif

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    int nc;

    enemy_hit_detector dut (
        .Clk          (Clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .bullet_active(bullet_active),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .fleet_x      (fleet_x),
        .fleet_y      (fleet_y),
        .enemy_status (enemy_status),
        .enemy_hit    (enemy_hit),
        .collision    (collision),
        .bullet_kill  (bullet_kill),
        .busy         (busy)
`ifdef KILL_COUNT_EN
        ,
        .kills        (kills),
        .wave_clear   (wave_clear)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // frame_start is sampled on the edge inside this task; afterwards cyc==1
    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        cyc = 1;
    endtask

    task automatic run_until(input int n, output int coll);
        coll = 0;
        while (cyc < n) begin
            tick();
            if (collision === 1'b1) coll++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        assertions++; if (enemy_hit !== 7'd0) begin failures++; $display("FAIL reset_enemy_hit: got %0d expected 0", enemy_hit); end
        assertions++; if (collision !== 1'b0) begin failures++; $display("FAIL reset_collision: got %b expected 0", collision); end
        assertions++; if (bullet_kill !== 1'b0) begin failures++; $display("FAIL reset_bullet_kill: got %b expected 0", bullet_kill); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_direct_hit();
        fleet_x = 10'd100; fleet_y = 10'd40; enemy_status = '1; bullet_active = 1'b1;
        bullet_x = 10'd150; bullet_y = 10'd105;
        start_frame();
        bullet_x = 10'd0; bullet_y = 10'd0; fleet_x = 10'd0; fleet_y = 10'd0;
        run_until(16, nc);
        assertions++; if (nc !== 0 || enemy_hit !== 7'd0) begin failures++; $display("FAIL hit_early: got coll=%0d hit=%0d expected coll=0 hit=0", nc, enemy_hit); end
        tick();
        assertions++; if (enemy_hit !== 7'd19 || collision !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hit_c17: got hit=%0d coll=%b busy=%b expected 19 0 1", enemy_hit, collision, busy); end
        tick();
        assertions++; if (collision !== 1'b1 || bullet_kill !== 1'b1 || enemy_hit !== 7'd19) begin failures++; $display("FAIL hit_c18: got coll=%b kill=%b hit=%0d expected 1 1 19", collision, bullet_kill, enemy_hit); end
        tick();
        assertions++; if (collision !== 1'b0 || bullet_kill !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hit_c19: got coll=%b kill=%b busy=%b expected 0 0 0", collision, bullet_kill, busy); end
        fleet_x = 10'd100; fleet_y = 10'd40;
    endtask

    task automatic test_dead_cell();
        bullet_x = 10'd150; bullet_y = 10'd105; enemy_status[2][3] = 1'b0;
        start_frame();
        run_until(60, nc);
        assertions++; if (busy !== 1'b1) begin failures++; $display("FAIL dead_busy60: got %b expected 1", busy); end
        tick();
        if (collision === 1'b1) nc++;
        assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL dead_busy61: got %b expected 0", busy); end
        assertions++; if (nc !== 0 || enemy_hit !== 7'd19) begin failures++; $display("FAIL dead_nohit: got coll=%0d hit=%0d expected 0 19", nc, enemy_hit); end
        enemy_status = '1;
    endtask

    task automatic test_inactive_and_edges();
        bullet_active = 1'b0;
        start_frame();
        assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL inactive_busy1: got %b expected 0", busy); end
        run_until(20, nc);
        assertions++; if (nc !== 0 || busy !== 1'b0) begin failures++; $display("FAIL inactive_idle: got coll=%0d busy=%b expected 0 0", nc, busy); end
        bullet_active = 1'b1;

        bullet_x = 10'd164; bullet_y = 10'd105;
        start_frame();
        run_until(64, nc);
        assertions++; if (nc !== 0 || busy !== 1'b0) begin failures++; $display("FAIL edge_miss: got coll=%0d busy=%b expected 0 0", nc, busy); end

        bullet_x = 10'd163; bullet_y = 10'd115;
        start_frame();
        run_until(17, nc);
        assertions++; if (nc !== 0 || enemy_hit !== 7'd19) begin failures++; $display("FAIL edge_hit_c17: got coll=%0d hit=%0d expected 0 19", nc, enemy_hit); end
        tick();
        assertions++; if (collision !== 1'b1) begin failures++; $display("FAIL edge_hit_c18: got %b expected 1", collision); end
        run_until(25, nc);
    endtask

    task automatic test_abort_and_overflow();
        bullet_x = 10'd150; bullet_y = 10'd105;
        start_frame();
        run_until(10, nc);
        assertions++; if (busy !== 1'b1 || nc !== 0) begin failures++; $display("FAIL abort_pre: got busy=%b coll=%0d expected 1 0", busy, nc); end
        bullet_x = 10'd124; bullet_y = 10'd60;
        start_frame();
        bullet_x = 10'd150; bullet_y = 10'd105;
        run_until(9, nc);
        assertions++; if (enemy_hit !== 7'd9 || nc !== 0) begin failures++; $display("FAIL abort_hit_c9: got hit=%0d coll=%0d expected 9 0", enemy_hit, nc); end
        tick();
        assertions++; if (collision !== 1'b1) begin failures++; $display("FAIL abort_coll_c10: got %b expected 1", collision); end
        run_until(30, nc);
        assertions++; if (nc !== 0 || enemy_hit !== 7'd9) begin failures++; $display("FAIL abort_single: got coll=%0d hit=%0d expected 0 9", nc, enemy_hit); end

        fleet_x = 10'd1000; bullet_x = 10'd5; bullet_y = 10'd105;
        start_frame();
        run_until(64, nc);
        assertions++; if (nc !== 0 || enemy_hit !== 7'd9) begin failures++; $display("FAIL overflow_wrap: got coll=%0d hit=%0d expected 0 9", nc, enemy_hit); end
        fleet_x = 10'd100;
    endtask

    task automatic test_reset_mid();
        bullet_x = 10'd150; bullet_y = 10'd105;
        start_frame();
        run_until(17, nc);
        assertions++; if (enemy_hit !== 7'd19 || nc !== 0) begin failures++; $display("FAIL rmid_mark: got hit=%0d coll=%0d expected 19 0", enemy_hit, nc); end
        reset = 1'b1;
        #1;
        assertions++; if (enemy_hit !== 7'd0 || collision !== 1'b0 || bullet_kill !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_clear: got hit=%0d coll=%b kill=%b busy=%b expected all 0", enemy_hit, collision, bullet_kill, busy); end
        #1;
        reset = 1'b0;
        tick();
        assertions++; if (collision !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_nostrobe: got coll=%b busy=%b expected 0 0", collision, busy); end
        bullet_x = 10'd124; bullet_y = 10'd60;
        start_frame();
        run_until(9, nc);
        assertions++; if (enemy_hit !== 7'd9) begin failures++; $display("FAIL rmid_rescan_hit: got %0d expected 9", enemy_hit); end
        tick();
        assertions++; if (collision !== 1'b1) begin failures++; $display("FAIL rmid_rescan_coll: got %b expected 1", collision); end
        run_until(20, nc);
    endtask

`ifdef KILL_COUNT_EN
    task automatic test_kill_count();
        int col, row, n;
        logic [6:0] exp_hit;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enemy_status = '1; fleet_x = 10'd100; fleet_y = 10'd40; bullet_active = 1'b1;
        for (int k = 0; k < 60; k++) begin
            col = k / 6;
            row = k % 6;
            exp_hit = {4'(col), 3'(row)};
            bullet_x = 10'(100 + col * 24 + 4);
            bullet_y = 10'(40 + row * 20 + 4);
            start_frame();
            n = 0;
            while (collision !== 1'b1 && n < 70) begin
                tick();
                n++;
            end
            assertions++; if (collision !== 1'b1 || enemy_hit !== exp_hit) begin failures++; $display("FAIL kc_hit_%0d: got coll=%b hit=%0d expected 1 %0d", k, collision, enemy_hit, exp_hit); end
            if (collision === 1'b1) enemy_status[enemy_hit[6:3]][enemy_hit[2:0]] = 1'b0;
            tick();
            assertions++; if (kills !== 6'(k + 1)) begin failures++; $display("FAIL kc_count_%0d: got %0d expected %0d", k, kills, k + 1); end
        end
        assertions++; if (kills !== 6'd60 || wave_clear !== 1'b1) begin failures++; $display("FAIL kc_wave: got kills=%0d wave=%b expected 60 1", kills, wave_clear); end
        bullet_x = 10'd104; bullet_y = 10'd44;
        start_frame();
        run_until(64, nc);
        assertions++; if (nc !== 0 || kills !== 6'd60 || wave_clear !== 1'b1) begin failures++; $display("FAIL kc_sat: got coll=%0d kills=%0d wave=%b expected 0 60 1", nc, kills, wave_clear); end
    endtask
`endif

    initial begin
        reset = 1'b1; frame_start = 1'b0; bullet_active = 1'b0;
        bullet_x = '0; bullet_y = '0; fleet_x = '0; fleet_y = '0; enemy_status = '1;
        @(posedge Clk);
        #1;
        test_reset();
        test_direct_hit();
        test_dead_cell();
        test_inactive_and_edges();
        test_abort_and_overflow();
        test_reset_mid();
`ifdef KILL_COUNT_EN
        test_kill_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/enemy_hit_detector.md
Name: enemy_hit_detector

Overview:
- Writer side of the enemy kill interface: produces the `enemy_hit` index and the `collision` strobe that the enemy status register consumes.
- Once per video frame it scans the 10x6 enemy formation against the player bullet tip.
- It emits at most one kill per frame.
- It also drives `bullet_kill` so the bullet logic retires the shot.

Parameters:
- COLS, 10, formation columns (index bits [6:3] of enemy_hit)
- ROWS, 6, formation rows (index bits [2:0] of enemy_hit)
- ENEMY_W, 16, enemy sprite width in pixels
- ENEMY_H, 16, enemy sprite height in pixels
- COL_PITCH, 24, horizontal distance between column origins
- ROW_PITCH, 20, vertical distance between row origins

Ports:
- Clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse per frame (vsync-derived); starts a scan
- bullet_active  in  1  player bullet in flight
- bullet_x  in  10  bullet tip x, pixels
- bullet_y  in  10  bullet tip y, pixels
- fleet_x  in  10  formation top-left x
- fleet_y  in  10  formation top-left y
- enemy_status  in  [9:0][5:0]  alive map readback; 1 = alive; indexed [col][row]
- enemy_hit  out  7  {col[3:0], row[2:0]} of the killed enemy
- collision  out  1  one-cycle kill strobe; enemy_hit stable before, during and after
- bullet_kill  out  1  one-cycle pulse, coincident with collision
- busy  out  1  scan in progress

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high, named reset.
- Reset values: enemy_hit=0, collision=0, bullet_kill=0, busy=0, FSM=IDLE, counters=0.
- FSM states: IDLE, SCAN, MARK, STROBE, DONE.
- IDLE/DONE + frame_start=1:
  - Latch bullet_x/y, fleet_x/y and bullet_active.
  - Clear col/row counters; load cell origin accumulators ex=fleet_x, ey=fleet_y.
  - Next state SCAN if latched bullet_active=1, else DONE.
- SCAN: evaluate one cell per cycle, col-major order (col outer 0..9, row inner 0..5).
  - Cell number k = col*6 + row; the last cell is k=59.
  - Match requires all of:
    - enemy_status[col][row]=1
    - ex <= bx <= ex+ENEMY_W-1
    - ey <= by <= ey+ENEMY_H-1
  - All adds and compares are 11-bit unsigned, so there is no wrap at 1023.
  - Origins are incremental: ey += ROW_PITCH per row; at row wrap, ey=fleet_y and ex += COL_PITCH. No multipliers.
  - On match: register enemy_hit={col,row}, go to MARK.
  - At k=59 with no match: go to DONE.
- MARK: one cycle, so enemy_hit settles ahead of the downstream edge-sensitive strobe. Next state STROBE.
- STROBE: collision=1 and bullet_kill=1 for exactly one cycle. Next state DONE.
- Latency from frame_start sampled at cycle 0:
  - Cell k is evaluated in cycle 1+k.
  - enemy_hit is valid from cycle 2+k.
  - collision is high in cycle 3+k only.
  - Worst case: collision in cycle 62; scan end with no hit in cycle 61.
- enemy_hit holds its last value until the next match; it is never cleared except by reset.
- busy=1 in SCAN, MARK, STROBE.
- frame_start during SCAN: abort, relatch all inputs, restart at cell 0.
- frame_start during MARK/STROBE: ignored; the strobe completes; the next frame_start is honoured.
- Only the first matching cell in scan order is killed. Overlapping sprites cannot produce two kills in one frame.
- Inputs are latched at frame_start; later changes do not affect the running scan. enemy_status is sampled live each cycle.
- Reset mid-scan or mid-strobe: immediate return to the reset values. A partial strobe is permitted to truncate.

Optional Feature:
- Macro: KILL_COUNT_EN.
- Defined:
  - Adds output `kills` (6 bits) and output `wave_clear` (1 bit).
  - kills increments on each STROBE and saturates at 60.
  - wave_clear is a level, high while kills==60.
  - Both are cleared by reset only.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package `invaders_pkg` holds:
  - COLS, ROWS, ENEMY_W, ENEMY_H, COL_PITCH, ROW_PITCH default constants.
  - Typedef `enemy_idx_t` (struct packed {logic [3:0] col; logic [2:0] row;}).
  - Typedef `enemy_map_t` (logic [9:0][5:0]).
  - Typedef `pix_t` (logic [9:0]).
- One natural sub-module: `cell_scanner`, which owns the col/row counters and the ex/ey accumulators, and outputs the current cell index, origin and a last-cell flag. The FSM and match logic stay in the top.

Test Plan:
- Direct hit:
  - Stimulus: fleet=(100,40), all alive, bullet_active=1, bullet=(150,105), frame_start at cycle 0.
  - Required: enemy_hit=7'd19 ({2,3}) from cycle 17; collision and bullet_kill high in cycle 18 only; busy low from cycle 19.
- Dead cell skipped:
  - Stimulus: same as direct hit, with enemy_status[2][3]=0.
  - Required: no collision; DONE at cycle 61; enemy_hit unchanged.
- Inactive bullet and edge misses:
  - Inactive: bullet_active=0 at frame_start gives no SCAN and busy stays 0.
  - Edge miss: bullet=(164,105) (one pixel right of col 2) gives no hit.
  - Edge hit: bullet=(163,115) gives a hit on {2,3}.
- Abort and overflow:
  - Abort: frame_start again at cycle 10 of a scan restarts from cell 0 with the new latched inputs.
  - Overflow: fleet_x=1000 and bullet_x=5 gives no false hit from wrap.
- Reset mid-operation:
  - Stimulus: reset asserted in the MARK cycle.
  - Required: collision never rises; all outputs 0 immediately; the next frame_start scans normally.
- KILL_COUNT_EN:
  - Stimulus: 60 frames, each aiming at the next alive cell, with status updated from the strobes.
  - Required: kills reaches 60 and wave_clear=1; a 61st hit attempt produces no collision and kills stays 60.
